// File: rtl/regfile_writeback_arbiter_if.sv
// Result buses between execute/memory/decode and the register file write-back arbiter.
interface regfile_writeback_arbiter_if #(
    parameter int BusWidth = 32
);
    logic                i_Alu_Valid;
    logic [3:0]          i_Alu_Address;
    logic [BusWidth-1:0] i_Alu_Data;
    logic                i_Load_Valid;
    logic [3:0]          i_Load_Address;
    logic [BusWidth-1:0] i_Load_Data;
    logic                o_Load_Ready;
    logic                i_Issue_Load;
    logic [3:0]          i_Issue_Address;
    logic [3:0]          i_Check_Address1;
    logic [3:0]          i_Check_Address2;
    logic                o_Pending1;
    logic                o_Pending2;
    logic                o_Write_Enable;
    logic [3:0]          o_Address_ToWrite;
    logic [BusWidth-1:0] o_Write_Data;
    logic                o_Branch_Valid;
    logic [BusWidth-1:0] o_Branch_Target;

    modport master (
        output i_Alu_Valid, i_Alu_Address, i_Alu_Data,
        output i_Load_Valid, i_Load_Address, i_Load_Data,
        output i_Issue_Load, i_Issue_Address, i_Check_Address1, i_Check_Address2,
        input  o_Load_Ready, o_Pending1, o_Pending2,
        input  o_Write_Enable, o_Address_ToWrite, o_Write_Data,
        input  o_Branch_Valid, o_Branch_Target
    );

    modport slave (
        input  i_Alu_Valid, i_Alu_Address, i_Alu_Data,
        input  i_Load_Valid, i_Load_Address, i_Load_Data,
        input  i_Issue_Load, i_Issue_Address, i_Check_Address1, i_Check_Address2,
        output o_Load_Ready, o_Pending1, o_Pending2,
        output o_Write_Enable, o_Address_ToWrite, o_Write_Data,
        output o_Branch_Valid, o_Branch_Target
    );
endinterface

// File: rtl/regfile_writeback_arbiter.sv
// Merges ALU and buffered load results onto the single register file write port,
// diverting R15 writes to the branch target and tracking outstanding loads.
module regfile_writeback_arbiter #(
    parameter int BusWidth  = 32,
    parameter int FifoDepth = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    regfile_writeback_arbiter_if.slave wb
);
    localparam int              PtrW      = $clog2(FifoDepth);
    localparam int              CntW      = PtrW + 1;
    localparam logic [CntW-1:0] FullCount = CntW'(FifoDepth);
    localparam logic [3:0]      PcAddr    = 4'd15;

    logic [3:0]          fifo_addr [FifoDepth];
    logic [BusWidth-1:0] fifo_data [FifoDepth];
    logic [PtrW-1:0]     wr_ptr;
    logic [PtrW-1:0]     rd_ptr;
    logic [CntW-1:0]     count;
    logic [14:0]         pending;
    logic [14:0]         pending_nxt;
    logic                enq;
    logic                deq;
    logic                sel_valid;
    logic [3:0]          sel_addr;
    logic [BusWidth-1:0] sel_data;

    // Ready comes from the registered count only, so a same-cycle dequeue never frees a slot.
    assign wb.o_Load_Ready = (count != FullCount);
    assign enq             = wb.i_Load_Valid && wb.o_Load_Ready;
    assign deq             = !wb.i_Alu_Valid && (count != '0);

    always_comb begin
        sel_valid = wb.i_Alu_Valid || deq;
        sel_addr  = fifo_addr[rd_ptr];
        sel_data  = fifo_data[rd_ptr];
        if (wb.i_Alu_Valid) begin
            sel_addr = wb.i_Alu_Address;
            sel_data = wb.i_Alu_Data;
        end
    end

    // Set is applied after clear so a newer load to the same register keeps its bit.
    always_comb begin
        pending_nxt = pending;
        if (deq && fifo_addr[rd_ptr] != PcAddr) begin
            pending_nxt[fifo_addr[rd_ptr]] = 1'b0;
        end
        if (wb.i_Issue_Load && wb.i_Issue_Address != PcAddr) begin
            pending_nxt[wb.i_Issue_Address] = 1'b1;
        end
    end

    assign wb.o_Pending1 = (wb.i_Check_Address1 != PcAddr) && pending[wb.i_Check_Address1];
    assign wb.o_Pending2 = (wb.i_Check_Address2 != PcAddr) && pending[wb.i_Check_Address2];

    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_addr[wr_ptr] <= wb.i_Load_Address;
            fifo_data[wr_ptr] <= wb.i_Load_Data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr               <= '0;
            rd_ptr               <= '0;
            count                <= '0;
            pending              <= '0;
            wb.o_Write_Enable    <= 1'b0;
            wb.o_Address_ToWrite <= '0;
            wb.o_Write_Data      <= '0;
            wb.o_Branch_Valid    <= 1'b0;
            wb.o_Branch_Target   <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (deq) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({enq, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            pending           <= pending_nxt;
            wb.o_Write_Enable <= 1'b0;
            wb.o_Branch_Valid <= 1'b0;
            if (sel_valid) begin
                if (sel_addr == PcAddr) begin
                    wb.o_Branch_Valid  <= 1'b1;
                    wb.o_Branch_Target <= sel_data;
                end else begin
                    wb.o_Write_Enable    <= 1'b1;
                    wb.o_Address_ToWrite <= sel_addr;
                    wb.o_Write_Data      <= sel_data;
                end
            end
        end
    end
endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Scoreboard bench for regfile_writeback_arbiter: a behavioural model queues expected
// writes at each edge, and a negedge monitor pops and compares them against the DUT.
module tb_regfile_writeback_arbiter;
    localparam int BW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regfile_writeback_arbiter_if #(.BusWidth(BW)) bus();

    regfile_writeback_arbiter #(.BusWidth(BW), .FifoDepth(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wb    (bus)
    );

    typedef struct {
        logic          br;
        logic [3:0]    addr;
        logic [BW-1:0] data;
        int            due;
    } wr_t;

    typedef struct {
        logic [3:0]    addr;
        logic [BW-1:0] data;
    } ld_t;

    wr_t           exp_q[$];
    ld_t           mfifo[$];
    logic [15:0]   m_pend = '0;
    logic [3:0]    m_addr = '0;
    logic [BW-1:0] m_data = '0;
    logic [BW-1:0] m_tgt = '0;
    int            cyc = 0;
    int            n_cmp = 0;
    int            n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference model: arbitration and scoreboard evaluated on the pre-edge view.
    always @(posedge clk) begin
        wr_t  e;
        ld_t  h;
        logic rdy;
        logic have;
        cyc++;
        if (!rst_n) begin
            exp_q.delete();
            mfifo.delete();
            m_pend = '0;
            m_addr = '0;
            m_data = '0;
            m_tgt  = '0;
        end else begin
            rdy  = (mfifo.size() != 4);
            have = 1'b0;
            if (bus.i_Alu_Valid) begin
                e.addr = bus.i_Alu_Address;
                e.data = bus.i_Alu_Data;
                have   = 1'b1;
            end else if (mfifo.size() > 0) begin
                h      = mfifo.pop_front();
                e.addr = h.addr;
                e.data = h.data;
                have   = 1'b1;
                if (h.addr != 4'd15) m_pend[h.addr] = 1'b0;
            end
            if (have) begin
                e.br  = (e.addr == 4'd15);
                e.due = cyc;
                exp_q.push_back(e);
                if (e.br) m_tgt = e.data;
                else begin
                    m_addr = e.addr;
                    m_data = e.data;
                end
            end
            if (bus.i_Issue_Load && bus.i_Issue_Address != 4'd15) m_pend[bus.i_Issue_Address] = 1'b1;
            if (bus.i_Load_Valid && rdy) begin
                h.addr = bus.i_Load_Address;
                h.data = bus.i_Load_Data;
                mfifo.push_back(h);
            end
        end
    end

    always @(negedge clk) begin
        wr_t e;
        if (cyc >= 1) begin
            if (bus.o_Write_Enable || bus.o_Branch_Valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_strobe", {bus.o_Write_Enable, bus.o_Branch_Valid}, 2'b00);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_cycle", cyc, e.due);
                    check("wr_branch", bus.o_Branch_Valid, e.br);
                    check("wr_enable", bus.o_Write_Enable, !e.br);
                end
            end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                e = exp_q.pop_front();
                check("missing_write", bus.o_Write_Enable || bus.o_Branch_Valid, 1'b1);
            end
            check("wr_addr", bus.o_Address_ToWrite, m_addr);
            check("wr_data", bus.o_Write_Data, m_data);
            check("br_target", bus.o_Branch_Target, m_tgt);
            check("load_ready", bus.o_Load_Ready, mfifo.size() != 4);
            check("pending1", bus.o_Pending1, m_pend[bus.i_Check_Address1]);
            check("pending2", bus.o_Pending2, m_pend[bus.i_Check_Address2]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        bus.i_Alu_Valid  = 1'b0;
        bus.i_Load_Valid = 1'b0;
        bus.i_Issue_Load = 1'b0;
    endtask

    initial begin
        int   li;
        int   c5;
        logic acc;
        bus.i_Alu_Address    = '0;
        bus.i_Alu_Data       = '0;
        bus.i_Load_Address   = '0;
        bus.i_Load_Data      = '0;
        bus.i_Issue_Address  = '0;
        bus.i_Check_Address1 = 4'd7;
        bus.i_Check_Address2 = 4'd9;
        quiet();

        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        check("rst_we", bus.o_Write_Enable, 1'b0);
        check("rst_bv", bus.o_Branch_Valid, 1'b0);
        check("rst_ready", bus.o_Load_Ready, 1'b1);
        check("rst_pend", {bus.o_Pending1, bus.o_Pending2}, 2'b00);

        // ALU write
        bus.i_Alu_Valid = 1'b1; bus.i_Alu_Address = 4'd3; bus.i_Alu_Data = 32'hDEADBEEF;
        tick();
        quiet();
        check("alu_we", bus.o_Write_Enable, 1'b1);
        check("alu_data", bus.o_Write_Data, 32'hDEADBEEF);
        tick();
        check("alu_one_cycle", bus.o_Write_Enable, 1'b0);
        repeat (2) tick();

        // Load-use hazard on R7
        bus.i_Issue_Load = 1'b1; bus.i_Issue_Address = 4'd7;
        tick();
        quiet();
        check("hazard_set", bus.o_Pending1, 1'b1);
        bus.i_Load_Valid = 1'b1; bus.i_Load_Address = 4'd7; bus.i_Load_Data = 32'h12345678;
        tick();
        quiet();
        check("hazard_held", bus.o_Pending1, 1'b1);
        tick();
        check("hazard_clear", bus.o_Pending1, 1'b0);
        check("hazard_wr_addr", bus.o_Address_ToWrite, 4'd7);
        repeat (2) tick();

        // ALU/load collision
        bus.i_Alu_Valid = 1'b1;  bus.i_Alu_Address = 4'd1;  bus.i_Alu_Data = 32'h11;
        bus.i_Load_Valid = 1'b1; bus.i_Load_Address = 4'd2; bus.i_Load_Data = 32'h22;
        tick();
        quiet();
        check("coll_first", bus.o_Address_ToWrite, 4'd1);
        tick();
        check("coll_second", bus.o_Address_ToWrite, 4'd2);
        repeat (2) tick();

        // FIFO fill under a 6-cycle ALU burst
        li = 0;
        c5 = -1;
        bus.i_Check_Address2 = 4'd10;
        for (int c = 0; c < 14; c++) begin
            bus.i_Alu_Valid   = (c < 6);
            bus.i_Alu_Address = 4'(c);
            bus.i_Alu_Data    = 32'hA0 + 32'(c);
            bus.i_Load_Valid  = (li < 5);
            bus.i_Load_Address = 4'(8 + li);
            bus.i_Load_Data   = 32'h1000 + 32'(li);
            bus.i_Issue_Load  = (c < 5);
            bus.i_Issue_Address = 4'(8 + c);
            acc = bus.i_Load_Valid && bus.o_Load_Ready;
            tick();
            if (acc) begin
                li++;
                if (li == 4) check("fifo_full_ready", bus.o_Load_Ready, 1'b0);
                if (li == 5) c5 = c;
            end
        end
        quiet();
        check("fifo_5th_accept", c5, 7);
        repeat (3) tick();

        // R15 diversion from ALU and from the load FIFO
        bus.i_Check_Address1 = 4'd15;
        bus.i_Alu_Valid = 1'b1; bus.i_Alu_Address = 4'd15; bus.i_Alu_Data = 32'h100;
        bus.i_Issue_Load = 1'b1; bus.i_Issue_Address = 4'd15;
        tick();
        quiet();
        check("r15_bv", bus.o_Branch_Valid, 1'b1);
        check("r15_target", bus.o_Branch_Target, 32'h100);
        check("r15_we", bus.o_Write_Enable, 1'b0);
        check("r15_pend", bus.o_Pending1, 1'b0);
        bus.i_Load_Valid = 1'b1; bus.i_Load_Address = 4'd15; bus.i_Load_Data = 32'h200;
        tick();
        quiet();
        tick();
        check("r15_load_target", bus.o_Branch_Target, 32'h200);
        repeat (2) tick();

        // Reset while loads are buffered and pending
        bus.i_Check_Address1 = 4'd5;
        bus.i_Issue_Load = 1'b1; bus.i_Issue_Address = 4'd5;
        bus.i_Alu_Valid = 1'b1;  bus.i_Alu_Address = 4'd4; bus.i_Alu_Data = 32'h44;
        bus.i_Load_Valid = 1'b1; bus.i_Load_Address = 4'd5; bus.i_Load_Data = 32'h55;
        tick();
        bus.i_Issue_Load = 1'b0;
        bus.i_Load_Address = 4'd6; bus.i_Load_Data = 32'h66;
        tick();
        quiet();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_rst_pend", bus.o_Pending1, 1'b0);
        check("mid_rst_data", bus.o_Write_Data, 32'h0);
        repeat (4) tick();
        check("mid_rst_no_write", bus.o_Write_Enable, 1'b0);

        for (int i = 0; i < 50 && exp_q.size() > 0; i++) tick();
        check("drain", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/regfile_writeback_arbiter.md
# regfile_writeback_arbiter

Merges the two result sources of the ARM core, the single-cycle ALU and the variable-latency load unit, onto the register file's single write port. It buffers load returns in a small FIFO, arbitrates with fixed ALU priority, and keeps a pending-load scoreboard that decode uses for load-use hazard stalls. Results addressed to R15 are diverted to a branch-target output instead of the register file. It sits between execute/memory and `regfile`, driving its write enable, write address and write data inputs.

## Interface
- BusWidth, 32, data width
- FifoDepth, 4, load-return FIFO entries (power of two, ≥2)
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- i_Alu_Valid  in  1  ALU result valid; always accepted
- i_Alu_Address  in  4  ALU destination register
- i_Alu_Data  in  BusWidth  ALU result
- i_Load_Valid  in  1  load return valid
- i_Load_Address  in  4  load destination register
- i_Load_Data  in  BusWidth  loaded data
- o_Load_Ready  out  1  FIFO can accept a load return
- i_Issue_Load  in  1  a load is issued this cycle
- i_Issue_Address  in  4  destination of the issued load
- i_Check_Address1, i_Check_Address2  in  4  decode source registers
- o_Pending1, o_Pending2  out  1  source has an outstanding load (combinational)
- o_Write_Enable  out  1  register file write strobe
- o_Address_ToWrite  out  4  register file write address (0–14 only)
- o_Write_Data  out  BusWidth  register file write data
- o_Branch_Valid  out  1  R15 write pulse
- o_Branch_Target  out  BusWidth  new PC value

## Operation
- Load FIFO: enqueue when i_Load_Valid && o_Load_Ready. o_Load_Ready = (count != FifoDepth), computed from registered count. A dequeue in the same cycle does not make a full FIFO ready. i_Load_Valid while not ready is ignored; the source must hold it.
- Arbitration, evaluated once per cycle:
  - If i_Alu_Valid, the ALU result is selected and the FIFO head waits.
  - Otherwise, if the FIFO is non-empty, the head is dequeued and selected.
  - Otherwise nothing is selected.
- Selected address 0–14: registered onto o_Write_Enable, o_Address_ToWrite and o_Write_Data. o_Branch_Valid stays 0.
- Selected address 15: registered onto o_Branch_Valid and o_Branch_Target. o_Write_Enable stays 0.
- With no selection, both strobes are 0 and address/data hold their previous values.
- Scoreboard: 15-bit pending vector, one bit per R0–R14.
  - Set bit on i_Issue_Load for address 0–14. Address 15 is not tracked.
  - Clear bit when a dequeued FIFO entry with that address is selected.
  - Set and clear of the same bit in the same cycle: set wins, because it marks a newer load.
  - ALU writes never clear pending bits.
- o_PendingN = pending[i_Check_AddressN]. Address 15 always returns 0.
- Count arithmetic: count is $clog2(FifoDepth)+1 bits. Read and write pointers wrap modulo FifoDepth. Simultaneous enqueue and dequeue leaves count unchanged.

## Timing
- ALU result at edge N appears on the write port after edge N+1: 1-cycle latency.
- Load return enqueued at edge N, with an empty FIFO and no ALU traffic, is written after edge N+2: 2-cycle latency.
- Each consecutive cycle with i_Alu_Valid delays the FIFO head by one cycle. There is no starvation guard; ALU bursts are bounded by the pipeline.
- A pending bit clears in the same cycle the write strobe is registered. o_PendingN drops one cycle before the register file holds the data; decode forwarding covers this gap.
- Reset, sampled at an edge with rst_n=0:
  - o_Write_Enable=0, o_Address_ToWrite=0, o_Write_Data=0.
  - o_Branch_Valid=0, o_Branch_Target=0.
  - FIFO emptied, so o_Load_Ready=1 from the next cycle.
  - Scoreboard cleared, so all o_PendingN=0.
- Reset mid-operation discards buffered loads and pending bits with no write.

## Test plan
- Reset then idle: drive rst_n=0 for 2 cycles, then release. Required: o_Write_Enable=0, o_Branch_Valid=0, o_Load_Ready=1, o_Pending1/2=0.
- ALU write: i_Alu_Valid with R3=0xDEADBEEF at edge 5. Required: o_Write_Enable=1, address 3, data 0xDEADBEEF after edge 6, for exactly one cycle.
- Load hazard: issue a load to R7, then check address 7. Required: o_Pending1=1. Return 0x12345678 for R7 with no ALU traffic. Required: write two edges later, and o_Pending1=0 from the write cycle onward.
- Collision: ALU R1=0x11 and load R2=0x22 in the same cycle. Required: R1 written first cycle, R2 written next cycle.
- FIFO full: hold i_Alu_Valid high for 6 cycles while pushing 5 load returns. Required: o_Load_Ready=0 after 4 accepted. The 5th return is accepted only after the ALU releases, and all 4+1 loads are written in order.
- R15 diversion: ALU to address 15 with data 0x100. Required: o_Branch_Valid=1 and o_Branch_Target=0x100 after one edge, with o_Write_Enable=0. A load issued to R15 leaves o_Pending=0.
